// File: rtl/pulse_meter_pkg.sv
// Shared constants and state encoding for the pulse period meter.
// States are plain localparams so legacy code can compare against them directly.
package pulse_meter_pkg;

  localparam int DEF_CNT_WIDTH = 26;
  localparam int DEF_TIMEOUT   = 5000000;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = ST_IDLE,
    MEASURE = ST_MEASURE
  } state_e;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Bundle of the meter's signal input and measurement results.
// The source modport drives the square wave; the meter modport produces results.
interface pulse_period_meter_if #(parameter int W = 26);
  logic         sig;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         valid;
  logic         locked;
  logic         timeout;

  // No handshake: the consumer samples period/high in the cycle valid is high.
  modport master (output sig, input period, input high, input valid, input locked, input timeout);
  modport slave  (input sig, output period, output high, output valid, output locked, output timeout);
endinterface

// File: rtl/pulse_period_meter_sync.sv
// sync_edge_detect: two-flop synchroniser plus history flop, producing
// single-cycle rise/fall strobes. Reusable for button inputs.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [2:0] s_q, s_d;

  always_comb begin
    s_d = {s_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) s_q <= '0;
    else     s_q <= s_d;
  end

  assign rise = s_q[1] & ~s_q[2];
  assign fall = ~s_q[1] & s_q[2];
endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of a slow square wave in system clock cycles,
// with a strobe per completed cycle and a loss-of-signal timeout.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_SIG,
  output logic [CNT_WIDTH-1:0] o_PERIOD,
  output logic [CNT_WIDTH-1:0] o_HIGH,
  output logic                 o_VALID,
  output logic                 o_LOCKED,
  output logic                 o_TIMEOUT
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] TO_VAL  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic rise, fall;

  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;

  sync_edge_detect u_sync (
    .clk  (i_CLK),
    .rst  (i_RST),
    .din  (i_SIG),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_d   = state_q;
    hi_lat_d  = hi_lat_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;

    if (rise)                 cnt_d = CNT_ONE;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_MEASURE;
      end
      default: begin
        if (fall) hi_lat_d = cnt_q;
        // A rise on the timeout cycle wins: it is a valid period of exactly TIMEOUT.
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_lat_q;
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end else if (cnt_q == TO_VAL) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          period_d  = '0;
          high_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_lat_q  <= hi_lat_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_PERIOD  = period_q;
  assign o_HIGH    = high_q;
  assign o_VALID   = valid_q;
  assign o_LOCKED  = locked_q;
  assign o_TIMEOUT = timeout_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter with CNT_WIDTH=8, TIMEOUT=100.
// Expected {period,high} pairs and timeout cycles are queued as stimulus is driven.
module tb_pulse_period_meter;
  localparam int CW = 8;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pulse_period_meter_if #(.W(CW)) pm_if ();

  pulse_period_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_SIG     (pm_if.sig),
    .o_PERIOD  (pm_if.period),
    .o_HIGH    (pm_if.high),
    .o_VALID   (pm_if.valid),
    .o_LOCKED  (pm_if.locked),
    .o_TIMEOUT (pm_if.timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [2*CW-1:0] exp_q[$];
  int              exp_to_q[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  bit              armed = 1'b0;
  int              prev_p = 0;
  int              prev_h = 0;
  int              last_rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // drivers: every task leaves time at posedge+3
  task automatic hold(input logic v, input int n);
    pm_if.sig = v;
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      if (armed) exp_q.push_back({CW'(prev_p), CW'(prev_h)});
      armed         = 1'b1;
      prev_p        = p;
      prev_h        = h;
      last_rise_cyc = cyc;
      hold(1'b1, h);
      hold(1'b0, p - h);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #3;
    rst   = 1'b0;
    armed = 1'b0;
  endtask

  // monitor: samples 1 time unit after each rising edge
  initial begin
    logic [2*CW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pm_if.valid && pm_if.timeout) check("valid_and_timeout", 1, 0);
      if (pm_if.valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("period", 32'(pm_if.period), 32'(e[2*CW-1:CW]));
          check("high", 32'(pm_if.high), 32'(e[CW-1:0]));
          check("locked_on_valid", 32'(pm_if.locked), 1);
        end
      end
      if (pm_if.timeout) begin
        if (exp_to_q.size() == 0) begin
          check("unexpected_timeout", 1, 0);
        end else begin
          check("timeout_cycle", 32'(cyc), 32'(exp_to_q.pop_front()));
          check("locked_after_to", 32'(pm_if.locked), 0);
          check("period_after_to", 32'(pm_if.period), 0);
          check("high_after_to", 32'(pm_if.high), 0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 32'(pm_if.period), 0);
    check({tag, "_high"}, 32'(pm_if.high), 0);
    check({tag, "_valid"}, 32'(pm_if.valid), 0);
    check({tag, "_locked"}, 32'(pm_if.locked), 0);
    check({tag, "_timeout"}, 32'(pm_if.timeout), 0);
  endtask

  initial begin
    pm_if.sig = 1'b0;
    do_reset(3);
    check_all_zero("reset");

    // steady 10/4, then duty change to 20/15
    wave(10, 4, 5);
    check("locked_steady", 32'(pm_if.locked), 1);
    wave(20, 15, 3);

    // input held low after lock: timeout 103 cycles after the last driven rise
    exp_to_q.push_back(last_rise_cyc + 3 + TO);
    armed = 1'b0;
    hold(1'b0, 150);
    check("locked_idle", 32'(pm_if.locked), 0);

    // rise exactly on cnt == TIMEOUT wins
    wave(TO, 50, 3);

    // lock at 10/4, then reset mid-period
    wave(10, 4, 3);
    if (armed) exp_q.push_back({CW'(prev_p), CW'(prev_h)});
    armed = 1'b0;
    hold(1'b1, 4);
    hold(1'b0, 2);
    do_reset(1);
    check_all_zero("mid_reset");
    hold(1'b0, 5);
    wave(10, 4, 3);
    hold(1'b0, 5);

    // constant high after a single rise from a fresh reset
    do_reset(1);
    exp_to_q.push_back(cyc + 3 + TO);
    hold(1'b1, 150);
    check("locked_const_high", 32'(pm_if.locked), 0);
    hold(1'b0, 10);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("exp_to_q_drained", 32'(exp_to_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
